// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, response codes and FSM states.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_BUS      = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_RESP = 2'b11
    } state_e;

    function automatic logic [3:0] size_bytes(input size_e sz);
        case (sz)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/mask placement and load lane extraction with extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  size_e                         size,
    input  logic                          is_unsigned,
    input  logic [$clog2(XLEN/8)-1:0]     offset,
    input  logic [XLEN-1:0]               st_data,
    output logic [XLEN-1:0]               st_lanes,
    output logic [XLEN/8-1:0]             st_mask,
    input  logic [XLEN-1:0]               ld_word,
    output logic [XLEN-1:0]               ld_data
);
    localparam int NB = XLEN / 8;

    logic [3:0]      nbytes;
    logic [15:0]     mask_wide;
    logic [XLEN-1:0] ld_shift;
    logic [XLEN-1:0] keep;
    logic            sgn;

    assign nbytes    = size_bytes(size);
    assign mask_wide = ((16'd1 << nbytes) - 16'd1) << offset;
    assign st_mask   = mask_wide[NB-1:0];
    assign st_lanes  = st_data << {offset, 3'b000};
    assign ld_shift  = ld_word >> {offset, 3'b000};

    // Bytes below the access size are kept; the rest become extension bits.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_keep
            assign keep[8*gi +: 8] = (4'(gi) < nbytes) ? 8'hFF : 8'h00;
        end
    endgenerate

    always_comb begin
        sgn = 1'b0;
        case (size)
            SZ_B:    sgn = ld_shift[7];
            SZ_H:    sgn = ld_shift[15];
            SZ_W:    sgn = ld_shift[31];
            default: sgn = ld_shift[XLEN-1];
        endcase
    end

    assign ld_data = (ld_shift & keep) | ((sgn && !is_unsigned) ? ~keep : '0);

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit with valid/ready on core and memory sides,
// misalignment detection, bus-error reporting and a REQ+WAIT timeout.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic [1:0]          rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_wen,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [XLEN/8-1:0]   mem_req_wmask,
    input  logic                mem_rsp_valid,
    output logic                mem_rsp_ready,
    input  logic [XLEN-1:0]     mem_rsp_rdata,
    input  logic                mem_rsp_err
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    state_e              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                wen_reg;
    size_e               size_reg;
    logic                uns_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [XLEN-1:0]     wdata_reg;
    logic [XLEN-1:0]     rdata_reg;
    err_e                err_reg;

    logic [3:0]          req_bytes_m1;
    logic [3:0]          req_lo;
    logic                req_bad;
    logic                timeout_hit;
    logic [XLEN-1:0]     st_lanes;
    logic [NB-1:0]       st_mask;
    logic [XLEN-1:0]     ld_data;

    assign req_bytes_m1 = size_bytes(size_e'(req_size)) - 4'd1;
    assign req_lo       = {{(4-OFF_W){1'b0}}, req_addr[OFF_W-1:0]};
    assign req_bad      = ((req_lo & req_bytes_m1) != 4'd0) ||
                          ((req_size == 2'b11) && (XLEN == 32));

    // Fires on the TIMEOUT_CYCLES-th cycle spent in REQ+WAIT.
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) &&
                          (32'(cnt_reg) == 32'(TIMEOUT_CYCLES - 1));

    lsu_align #(.XLEN(XLEN)) u_align (
        .size        (size_reg),
        .is_unsigned (uns_reg),
        .offset      (addr_reg[OFF_W-1:0]),
        .st_data     (wdata_reg),
        .st_lanes    (st_lanes),
        .st_mask     (st_mask),
        .ld_word     (mem_rsp_rdata),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    state_next = req_bad ? S_RESP : S_REQ;
                    cnt_next   = '0;
                end
            end
            S_REQ: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (timeout_hit)        state_next = S_RESP;
                else if (mem_req_ready) state_next = S_WAIT;
            end
            S_WAIT: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (timeout_hit)        state_next = S_RESP;
                else if (mem_rsp_valid) state_next = S_RESP;
            end
            default: begin
                if (rsp_ready) state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            wen_reg   <= 1'b0;
            size_reg  <= SZ_B;
            uns_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= ERR_OK;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == S_IDLE && req_valid) begin
                wen_reg   <= req_wen;
                size_reg  <= size_e'(req_size);
                uns_reg   <= req_unsigned;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                if (req_bad) begin
                    err_reg   <= ERR_MISALIGN;
                    rdata_reg <= '0;
                end
            end
            if ((state_reg == S_REQ || state_reg == S_WAIT) && timeout_hit) begin
                err_reg   <= ERR_TIMEOUT;
                rdata_reg <= '0;
            end else if (state_reg == S_WAIT && mem_rsp_valid) begin
                err_reg   <= mem_rsp_err ? ERR_BUS : ERR_OK;
                rdata_reg <= (mem_rsp_err || wen_reg) ? '0 : ld_data;
            end
        end
    end

    assign req_ready     = (state_reg == S_IDLE);
    assign mem_rsp_ready = (state_reg == S_IDLE) || (state_reg == S_WAIT);
    assign mem_req_valid = (state_reg == S_REQ);
    assign rsp_valid     = (state_reg == S_RESP);
    assign rsp_rdata     = rdata_reg;
    assign rsp_err       = err_reg;
    assign mem_req_wen   = wen_reg;
    assign mem_req_addr  = {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_req_wdata = wen_reg ? st_lanes : '0;
    assign mem_req_wmask = wen_reg ? st_mask : '0;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu (XLEN=32, TIMEOUT_CYCLES=8) with a small responsive memory model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
    logic [31:0] mem_rsp_rdata;

    always #5 clk = ~clk;

    lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wen       (req_wen),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_wen   (mem_req_wen),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_rdata (mem_rsp_rdata),
        .mem_rsp_err   (mem_rsp_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    int          r_lat, r_mreq;
    logic [31:0] r_rdata, r_maddr, r_mwdata;
    logic [1:0]  r_err;
    logic [3:0]  r_mwmask;
    bit          r_mreq_unstable, r_rsp_unstable, r_rr_bad, r_done;

    // Called at a negedge while the LSU is idle; request is accepted at cycle 0.
    task automatic run_access(input bit wen, input logic [1:0] size, input bit uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int rdy_delay, input logic [31:0] mrdata,
                              input bit merr, input int rsp_hold);
        int nvalid = 0;
        int hold   = 0;
        bit hs     = 0;
        bit seen   = 0;
        r_lat = -1; r_mreq = 0; r_rdata = 0; r_err = 0;
        r_maddr = 0; r_mwdata = 0; r_mwmask = 0;
        r_mreq_unstable = 0; r_rsp_unstable = 0; r_rr_bad = 0; r_done = 0;
        req_valid = 1; req_wen = wen; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        for (int cyc = 1; cyc <= 40 && !r_done; cyc++) begin
            @(negedge clk);
            req_valid = 0; mem_rsp_valid = 0; mem_req_ready = 0; rsp_ready = 0;
            if (hs) begin
                mem_rsp_valid = 1; mem_rsp_rdata = mrdata; mem_rsp_err = merr; hs = 0;
            end
            if (mem_req_valid) begin
                if (nvalid == 0) begin
                    r_maddr = mem_req_addr; r_mwdata = mem_req_wdata; r_mwmask = mem_req_wmask;
                end else if (mem_req_addr !== r_maddr || mem_req_wdata !== r_mwdata ||
                             mem_req_wmask !== r_mwmask) begin
                    r_mreq_unstable = 1;
                end
                nvalid++;
                r_mreq = nvalid;
                if (nvalid > rdy_delay) begin
                    mem_req_ready = 1; hs = 1;
                end
            end
            if (rsp_valid) begin
                if (!seen) begin
                    seen = 1; r_lat = cyc; r_rdata = rsp_rdata; r_err = rsp_err;
                end else if (rsp_rdata !== r_rdata || rsp_err !== r_err) begin
                    r_rsp_unstable = 1;
                end
                if (req_ready) r_rr_bad = 1;
                if (hold >= rsp_hold) begin
                    rsp_ready = 1; r_done = 1;
                end else begin
                    hold++;
                end
            end
        end
        @(negedge clk);
        rsp_ready = 0; mem_rsp_valid = 0; mem_req_ready = 0;
        check("rsp_budget", 32'(r_done), 32'd1);
        $display("access wen=%0d size=%0d uns=%0d addr=0x%08h -> err=%0d rdata=0x%08h lat=%0d mreq_cycles=%0d",
                 wen, size, uns, addr, r_err, r_rdata, r_lat, r_mreq);
    endtask

    int late_rsp;

    initial begin
        rst = 0; req_valid = 0; req_wen = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0; rsp_ready = 0; mem_req_ready = 0;
        mem_rsp_valid = 0; mem_rsp_rdata = 0; mem_rsp_err = 0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_mem_rsp_ready", 32'(mem_rsp_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_wmask", 32'(mem_req_wmask), 32'd0);
        rst = 1;
        @(negedge clk);

        // lb signed / unsigned from byte lane 3
        run_access(0, 2'b00, 0, 32'h8000_0003, 32'h0, 0, 32'h80FF_1234, 0, 0);
        check("lb_rdata", r_rdata, 32'hFFFF_FF80);
        check("lb_err", 32'(r_err), 32'd0);
        check("lb_lat", 32'(r_lat), 32'd3);
        check("lb_maddr", r_maddr, 32'h8000_0000);
        check("lb_wmask", 32'(r_mwmask), 32'd0);
        run_access(0, 2'b00, 1, 32'h8000_0003, 32'h0, 0, 32'h80FF_1234, 0, 0);
        check("lbu_rdata", r_rdata, 32'h0000_0080);

        // sh into upper half
        run_access(1, 2'b01, 0, 32'h8000_0002, 32'h1234_ABCD, 0, 32'h5555_5555, 0, 0);
        check("sh_maddr", r_maddr, 32'h8000_0000);
        check("sh_wdata", r_mwdata, 32'hABCD_0000);
        check("sh_wmask", 32'(r_mwmask), 32'hC);
        check("sh_rdata", r_rdata, 32'd0);
        check("sh_err", 32'(r_err), 32'd0);
        check("sh_lat", 32'(r_lat), 32'd3);

        // misaligned word, illegal double on a 32-bit core
        run_access(0, 2'b10, 0, 32'h8000_0002, 32'h0, 0, 32'h0, 0, 0);
        check("mis_lat", 32'(r_lat), 32'd1);
        check("mis_err", 32'(r_err), 32'd1);
        check("mis_mreq", 32'(r_mreq), 32'd0);
        check("mis_rdata", r_rdata, 32'd0);
        run_access(0, 2'b11, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0);
        check("ld_lat", 32'(r_lat), 32'd1);
        check("ld_err", 32'(r_err), 32'd1);
        check("ld_mreq", 32'(r_mreq), 32'd0);

        // memory never ready -> timeout after 8 cycles
        run_access(0, 2'b10, 0, 32'h8000_0040, 32'h0, 1000, 32'h0, 0, 0);
        check("to_err", 32'(r_err), 32'd3);
        check("to_rdata", r_rdata, 32'd0);
        check("to_mreq", 32'(r_mreq), 32'd8);
        check("to_lat", 32'(r_lat), 32'd9);
        // late memory response while idle must vanish
        mem_rsp_valid = 1; mem_rsp_rdata = 32'h1111_2222; mem_rsp_err = 0;
        late_rsp = 0;
        @(negedge clk);
        mem_rsp_valid = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid || mem_req_valid) late_rsp++;
            @(negedge clk);
        end
        check("late_rsp", 32'(late_rsp), 32'd0);
        check("late_req_ready", 32'(req_ready), 32'd1);

        // delayed ready, bus error, response held back for 5 cycles
        run_access(1, 2'b10, 0, 32'h8000_0010, 32'hCAFE_F00D, 3, 32'h0, 1, 5);
        check("be_err", 32'(r_err), 32'd2);
        check("be_rdata", r_rdata, 32'd0);
        check("be_mreq", 32'(r_mreq), 32'd4);
        check("be_lat", 32'(r_lat), 32'd6);
        check("be_wdata", r_mwdata, 32'hCAFE_F00D);
        check("be_wmask", 32'(r_mwmask), 32'hF);
        check("be_mreq_stable", 32'(r_mreq_unstable), 32'd0);
        check("be_rsp_stable", 32'(r_rsp_unstable), 32'd0);
        check("be_req_ready_low", 32'(r_rr_bad), 32'd0);

        // reset while waiting for memory abandons the access
        req_valid = 1; req_wen = 0; req_size = 2'b10; req_unsigned = 0;
        req_addr = 32'h100; req_wdata = 0;
        @(negedge clk);
        req_valid = 0;
        check("rw_mreq_valid", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0;
        check("rw_in_wait", 32'({mem_req_valid, mem_rsp_ready, req_ready}), 32'b010);
        rst = 0;
        @(negedge clk);
        rst = 1;
        late_rsp = 0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid) late_rsp++;
            @(negedge clk);
        end
        check("rw_no_stale", 32'(late_rsp), 32'd0);
        run_access(0, 2'b10, 0, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, 0, 0);
        check("rw_rdata", r_rdata, 32'hDEAD_BEEF);
        check("rw_err", 32'(r_err), 32'd0);
        check("rw_lat", 32'(r_lat), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Multi-cycle load/store unit for the NPC core. It replaces direct per-instruction memory DPI access with a valid/ready handshake on both the core side and the memory side.
- Generalised in data width (XLEN 32/64) and access size.
- Adds misalignment detection, bus-error reporting and a bus timeout.
- Sits between IDU/EXU (address from the ALU result) and the memory bridge / DPI memory model.

Parameters:
XLEN, 32, data width; 32 or 64
ADDR_W, 32, address width
TIMEOUT_CYCLES, 256, maximum cycles spent in REQ+WAIT before error; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
req_valid  in  1  core access request
req_ready  out  1  LSU can accept a request
req_wen  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=double
req_unsigned  in  1  loads: zero-extend instead of sign-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-aligned
rsp_valid  out  1  response available
rsp_ready  in  1  core accepts response
rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
rsp_err  out  2  00=ok, 01=misaligned/illegal size, 10=bus error, 11=timeout
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_wen  out  1  store
mem_req_addr  out  ADDR_W  req_addr with low log2(XLEN/8) bits cleared
mem_req_wdata  out  XLEN  store data shifted into its byte lanes
mem_req_wmask  out  XLEN/8  byte-lane enables; all zero for loads
mem_rsp_valid  in  1  memory response
mem_rsp_ready  out  1  LSU accepts memory response
mem_rsp_rdata  in  XLEN  full aligned word
mem_rsp_err  in  1  bus error

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, timeout counter=0, and all outputs 0 except req_ready=1 and mem_rsp_ready=1.
  - Reset overrides every state; an in-flight access is abandoned with no response.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1, mem_rsp_ready=1.
  - Stray memory responses (e.g. late after a timeout) are consumed and discarded.
  - On req_valid, latch the request.
    - If misaligned (addr mod bytes != 0) or size==11 with XLEN==32, go to RESP with err=01 and issue no memory request.
    - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1; addr, wdata, wmask and wen are held stable until mem_req_ready.
  - On handshake, go to WAIT.
- WAIT:
  - mem_rsp_ready=1.
  - On mem_rsp_valid, go to RESP and capture the result:
    - mem_rsp_err=1: err=10, rdata=0.
    - Otherwise: err=00, and rdata = the selected lanes from byte offset addr[low bits], extended per req_unsigned. Stores give rdata=0.
- RESP:
  - rsp_valid=1; rdata and err are held stable until rsp_ready.
  - On rsp_ready, go to IDLE. No new request is accepted in the same cycle; req_ready stays 0 outside IDLE.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES: go to RESP with err=11 and rdata=0, and drop mem_req_valid.
  - A timeout has priority over a handshake in the same cycle.
- Store lane rules:
  - wdata = req_wdata << (8*offset).
  - wmask = ((1<<bytes)-1) << offset, where bytes = 1<<size.
- Latency:
  - Aligned access with zero-wait memory: accept at cycle 0, mem_req_valid at cycle 1, mem_rsp at cycle 2, rsp_valid at cycle 3.
  - Misaligned access: rsp_valid at cycle 1.
- One outstanding access only; requests are never reordered.

Decomposition:
- lsu_pkg:
  - size enum (SZ_B/SZ_H/SZ_W/SZ_D)
  - err enum (ERR_OK/ERR_MISALIGN/ERR_BUS/ERR_TIMEOUT)
  - state enum (S_IDLE/S_REQ/S_WAIT/S_RESP)
  - function giving bytes-per-size
- Sub-module lsu_align: combinational.
  - Store path: wdata/wmask generation.
  - Load path: lane extraction plus sign/zero extension.
  - The FSM and timeout stay in lsu.

Test Plan:
- lb at 0x80000003, mem_rsp_rdata=0x80FF1234 -> rsp_rdata=0xFFFFFF80, err=00. The same access with req_unsigned=1 -> 0x00000080.
- sh wdata=0x1234ABCD at 0x80000002 -> mem_req_addr=0x80000000, wdata=0xABCD0000, wmask=4'b1100. Response gives rdata=0, err=00.
- lw at 0x80000002 -> rsp_valid at cycle 1, err=01, mem_req_valid never asserted. With XLEN=32, size=11 at 0x0 -> err=01.
- TIMEOUT_CYCLES=8 with mem_req_ready held 0 -> mem_req_valid drops and rsp err=11 after 8 cycles. A late mem_rsp_valid arriving in IDLE is discarded and no rsp_valid is produced.
- mem_req_ready delayed 3 cycles, then mem_rsp_err=1 -> err=10. Throughout the access, mem_req_addr, wdata and wmask stay stable, and rsp_ready held low for 5 cycles keeps rsp_valid, rdata and err stable with req_ready=0.
- rst=0 asserted in WAIT, followed by a new lw at 0x100 returning 0xDEADBEEF -> no stale response, rsp_rdata=0xDEADBEEF.
